regfile_port_ctrl: RTL and testbench

Initiator-side controller for the dual-port register file: turns operand-fetch requests (two source registers) and writeback requests into correctly timed `rd_*`/`wen_*`/`addr_*`/`din_*` strobes, and captures the registered, tri-stated read data into a held response. It sits between decode/writeback logic and the register file. It also arbitrates port B between writes and reads and resolves same-cycle write/read hazards.

---
 rtl/regfile_port_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_regfile_port_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_ctrl.sv
`timescale 1ns/1ps
// regfile_port_ctrl: initiator-side controller for the dual-port register file.
// It fetches two source operands. Port A is read-only. Port B carries the src2 read
// whenever a writeback is not using it, and writebacks always win port B.
// The controller also resolves a port-A read that lands on the same address as a
// port-B write in the same cycle.
// Build option REGFILE_BYPASS_EN: when it is defined, colliding writeback data is
// forwarded into the captured operand. When it is undefined (the default build), the
// colliding port-A read is dropped for that cycle and reissued on the next cycle.
module regfile_port_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src1,
  input  logic [ADDR_W-1:0] req_src2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_op1,
  output logic [DATA_W-1:0] rsp_op2,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_wen_a,
  output logic              rf_rd_a,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [DATA_W-1:0] rf_din_a,
  input  logic [DATA_W-1:0] rf_dout_a,
  output logic              rf_wen_b,
  output logic              rf_rd_b,
  output logic [ADDR_W-1:0] rf_addr_b,
  output logic [DATA_W-1:0] rf_din_b,
  input  logic [DATA_W-1:0] rf_dout_b
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CAP2  = 3'd2,
    CAP1  = 3'd3,
    CAPA  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src1_q;
  logic [ADDR_W-1:0] src2_q;
  logic              rd_a_prev;

  logic              wb_fire;
  logic              rd_a_want;
  logic [ADDR_W-1:0] rd_a_addr;
  logic              hazard_a;
  logic              port_b_busy;
  logic [DATA_W-1:0] cap1_val;
  logic [DATA_W-1:0] capa_val;

`ifdef REGFILE_BYPASS_EN
  logic              fwd1;
  logic              fwd2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
`else
  logic              b_lost;
`endif

  // Strobe generation and handshakes: strobes decode from the state and the live writeback inputs
  always_comb begin
    wb_ready    = ~rst;
    wb_fire     = wb_valid & ~rst;
    req_ready   = (state == IDLE) & ~rst;
    rsp_valid   = (state == RESP);
    rd_a_want   = (state == ISSUE) || (state == CAP1);
    rd_a_addr   = (state == ISSUE) ? src1_q : src2_q;
    hazard_a    = rd_a_want && wb_fire && (wb_addr == rd_a_addr);
`ifdef REGFILE_BYPASS_EN
    rf_rd_a     = rd_a_want;
    port_b_busy = wb_fire;
    cap1_val    = fwd1 ? fwd_data1 : rf_dout_a;
    capa_val    = fwd2 ? fwd_data2 : rf_dout_a;
`else
    rf_rd_a     = rd_a_want && !hazard_a;
    port_b_busy = wb_fire || b_lost;
    cap1_val    = rf_dout_a;
    capa_val    = rf_dout_a;
`endif
    rf_addr_a   = rf_rd_a ? rd_a_addr : '0;
    rf_wen_a    = 1'b0;
    rf_din_a    = '0;
    rf_rd_b     = (state == ISSUE) && !port_b_busy;
    rf_wen_b    = wb_fire;
    rf_addr_b   = wb_fire ? wb_addr : (rf_rd_b ? src2_q : '0);
    rf_din_b    = wb_fire ? wb_data : '0;
  end

  // Fetch sequencer: latches sources, steps the read/capture states and holds the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src1_q    <= '0;
      src2_q    <= '0;
      rd_a_prev <= 1'b0;
      rsp_op1   <= '0;
      rsp_op2   <= '0;
`ifdef REGFILE_BYPASS_EN
      fwd1      <= 1'b0;
      fwd2      <= 1'b0;
      fwd_data1 <= '0;
      fwd_data2 <= '0;
`else
      b_lost    <= 1'b0;
`endif
    end else begin
      rd_a_prev <= rf_rd_a;
      case (state)
        IDLE: begin
          if (req_valid) begin
            src1_q <= req_src1;
            src2_q <= req_src2;
`ifdef REGFILE_BYPASS_EN
            fwd1   <= 1'b0;
            fwd2   <= 1'b0;
`else
            b_lost <= 1'b0;
`endif
            state  <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef REGFILE_BYPASS_EN
          fwd1 <= hazard_a;
          if (hazard_a) begin
            fwd_data1 <= wb_data;
          end
          state <= port_b_busy ? CAP1 : CAP2;
`else
          if (hazard_a) begin
            b_lost <= 1'b1;
          end else begin
            state <= port_b_busy ? CAP1 : CAP2;
          end
`endif
        end
        CAP2: begin
          rsp_op1 <= rf_dout_a;
          rsp_op2 <= rf_dout_b;
          state   <= RESP;
        end
        CAP1: begin
          if (rd_a_prev) begin
            rsp_op1 <= cap1_val;
          end
`ifdef REGFILE_BYPASS_EN
          fwd2 <= hazard_a;
          if (hazard_a) begin
            fwd_data2 <= wb_data;
          end
          state <= CAPA;
`else
          if (!hazard_a) begin
            state <= CAPA;
          end
`endif
        end
        CAPA: begin
          rsp_op2 <= capa_val;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
`timescale 1ns/1ps
// tb_regfile_port_ctrl: directed vectors plus hand-written multi-cycle sequences for
// regfile_port_ctrl, with a small behavioural dual-port register file attached.
module tb_regfile_port_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [31:0] FLOAT = 32'hDEAD_BEEF;
`ifdef REGFILE_BYPASS_EN
  localparam int   HZ_LAT  = 4;
  localparam logic HZ_RD_A = 1'b1;
`else
  localparam int   HZ_LAT  = 5;
  localparam logic HZ_RD_A = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_src1 = '0;
  logic [ADDR_W-1:0] req_src2 = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_op1;
  logic [DATA_W-1:0] rsp_op2;
  logic              wb_valid = 1'b0;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              rf_wen_a;
  logic              rf_rd_a;
  logic [ADDR_W-1:0] rf_addr_a;
  logic [DATA_W-1:0] rf_din_a;
  logic [DATA_W-1:0] rf_dout_a;
  logic              rf_wen_b;
  logic              rf_rd_b;
  logic [ADDR_W-1:0] rf_addr_b;
  logic [DATA_W-1:0] rf_din_b;
  logic [DATA_W-1:0] rf_dout_b;

  logic [DATA_W-1:0] mem [32];

  int errors = 0;
  int checks = 0;
  int lat;

  typedef struct packed {
    logic        rv;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rr;
    logic        e_rr;
    logic        e_rv;
    logic        e_rda;
    logic [4:0]  e_aa;
    logic        e_rdb;
    logic        e_wenb;
    logic [4:0]  e_ab;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
  } vec_t;

  vec_t vecs [21];

  regfile_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op1(rsp_op1), .rsp_op2(rsp_op2),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_wen_a(rf_wen_a), .rf_rd_a(rf_rd_a), .rf_addr_a(rf_addr_a),
    .rf_din_a(rf_din_a), .rf_dout_a(rf_dout_a),
    .rf_wen_b(rf_wen_b), .rf_rd_b(rf_rd_b), .rf_addr_b(rf_addr_b),
    .rf_din_b(rf_din_b), .rf_dout_b(rf_dout_b)
  );

  always #5 clk = ~clk;

  // Register file model: registered reads (old value on a same-edge write), a fixed
  // pattern stands in for the floating bus when a port is not read
  always @(posedge clk) begin
    rf_dout_a <= rf_rd_a ? mem[rf_addr_a] : FLOAT;
    rf_dout_b <= rf_rd_b ? mem[rf_addr_b] : FLOAT;
    if (rf_wen_b) mem[rf_addr_b] <= rf_din_b;
  end

  function automatic vec_t mk(input logic rv, input logic [4:0] s1, input logic [4:0] s2,
                              input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                              input logic rr, input logic e_rr, input logic e_rv,
                              input logic e_rda, input logic [4:0] e_aa, input logic e_rdb,
                              input logic e_wenb, input logic [4:0] e_ab,
                              input logic [31:0] e_op1, input logic [31:0] e_op2);
    vec_t v;
    v = {rv, s1, s2, wv, wa, wd, rr, e_rr, e_rv, e_rda, e_aa, e_rdb, e_wenb, e_ab, e_op1, e_op2};
    return v;
  endfunction

  function automatic logic [15:0] dutStrobes();
    return {wb_ready, req_ready, rsp_valid, rf_rd_a, rf_addr_a, rf_rd_b, rf_wen_b, rf_addr_b};
  endfunction

  function automatic logic [15:0] expStrobes(input logic rr, input logic rv, input logic rda,
                                             input logic [4:0] aa, input logic rdb,
                                             input logic wenb, input logic [4:0] ab);
    return {1'b1, rr, rv, rda, aa, rdb, wenb, ab};
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid = v.rv;
    req_src1  = v.s1;
    req_src2  = v.s2;
    wb_valid  = v.wv;
    wb_addr   = v.wa;
    wb_data   = v.wd;
    rsp_ready = v.rr;
  endtask

  task automatic drive(input logic rv, input logic [4:0] s1, input logic [4:0] s2,
                       input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rr);
    req_valid = rv;
    req_src1  = s1;
    req_src2  = s2;
    wb_valid  = wv;
    wb_addr   = wa;
    wb_data   = wd;
    rsp_ready = rr;
  endtask

  // Counts negedges from the current cycle index until rsp_valid, bounded
  task automatic waitRsp(input int start, output int cycles);
    cycles = start;
    #1;
    while (!rsp_valid && cycles < 14) begin
      @(negedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    // Vectors: one entry per cycle, inputs then expected outputs
    vecs[0]  = mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h11,   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 32'h0,    32'h0);
    vecs[1]  = mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h22,   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 32'h0,    32'h0);
    vecs[2]  = mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h5A5A, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 32'h0,    32'h0);
    vecs[3]  = mk(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,    32'h0);
    vecs[4]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd7, 32'h0,    32'h0);
    vecs[5]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,    32'h0);
    vecs[6]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h11,   32'h22);
    vecs[7]  = mk(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,    32'h0);
    vecs[8]  = mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h55,   1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd9, 32'h0,    32'h0);
    vecs[9]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0,    32'h0);
    vecs[10] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,    32'h0);
    vecs[11] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h11,   32'h22);
    vecs[12] = mk(1'b1, 5'd9, 5'd5, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,    32'h0);
    vecs[13] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 5'd5, 32'h0,    32'h0);
    vecs[14] = mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h66,   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 32'h0,    32'h0);
    vecs[15] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h55,   32'h5A5A);
    vecs[16] = mk(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,    32'h0);
    vecs[17] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 32'h0,    32'h0);
    vecs[18] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,    32'h0);
    vecs[19] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h5A5A, 32'h5A5A);
    vecs[20] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,    32'h0);

    // Reset state: nothing accepted or strobed, even with a writeback offered
    drive(1'b1, 5'd3, 5'd7, 1'b1, 5'd3, 32'hFF, 1'b0);
    #2;
    checkOutput("reset_strobes", 96'(dutStrobes()), 96'(0));
    checkOutput("reset_ops", 96'({rsp_op1, rsp_op2}), 96'(0));
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_strobes", i), 96'(dutStrobes()),
                  96'(expStrobes(vecs[i].e_rr, vecs[i].e_rv, vecs[i].e_rda, vecs[i].e_aa,
                                 vecs[i].e_rdb, vecs[i].e_wenb, vecs[i].e_ab)));
      checkOutput($sformatf("vec%0d_din_b", i), 96'(rf_din_b), 96'(vecs[i].wv ? vecs[i].wd : 32'h0));
      checkOutput($sformatf("vec%0d_port_a_wr", i), 96'({rf_wen_a, rf_din_a}), 96'(0));
      if (vecs[i].e_rv) begin
        checkOutput($sformatf("vec%0d_ops", i), 96'({rsp_op1, rsp_op2}), 96'({vecs[i].e_op1, vecs[i].e_op2}));
      end
    end

    // Backpressure: response held for 6 cycles, next request accepted right after
    @(negedge clk);
    drive(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 checkOutput("bp_accept", 96'(req_ready), 96'(1));
    @(negedge clk);
    drive(1'b1, 5'd5, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 checkOutput("bp_issue_busy", 96'(req_ready), 96'(0));
    @(negedge clk);
    #1 checkOutput("bp_cap_busy", 96'(req_ready), 96'(0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 checkOutput($sformatf("bp_hold%0d", k), 96'({rsp_valid, req_ready, rsp_op1, rsp_op2}),
                     {30'd0, 1'b1, 1'b0, 32'h11, 32'h22});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 checkOutput("bp_handshake", 96'({rsp_valid, rsp_op1, rsp_op2}), {31'd0, 1'b1, 32'h11, 32'h22});
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 checkOutput("bp_next_accept", 96'({rsp_valid, req_ready}), 96'(2'b01));
    @(negedge clk);
    req_valid = 1'b0;
    #1 checkOutput("bp_next_issue", 96'(dutStrobes()),
                   96'(expStrobes(1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 5'd9)));
    @(negedge clk);
    @(negedge clk);
    #1 checkOutput("bp_next_ops", 96'({rsp_valid, rsp_op1, rsp_op2}), {31'd0, 1'b1, 32'h5A5A, 32'h66});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Hazard on src1: writeback to reg 3 during ISSUE of src1=3
    drive(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 checkOutput("hz1_accept", 96'(req_ready), 96'(1));
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hAB, 1'b0);
    #1 checkOutput("hz1_issue", 96'({rf_wen_b, rf_rd_a, rf_rd_b}), 96'({1'b1, HZ_RD_A, 1'b0}));
    @(negedge clk);
    wb_valid = 1'b0;
    waitRsp(2, lat);
    checkOutput("hz1_latency", 96'(lat), 96'(HZ_LAT));
    checkOutput("hz1_ops", 96'({rsp_op1, rsp_op2}), 96'({32'hAB, 32'h22}));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Hazard on src2: unrelated wb in ISSUE, then wb to reg 7 while CAP1 reads src2=7
    drive(1'b1, 5'd5, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 checkOutput("hz2_accept", 96'(req_ready), 96'(1));
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h1, 1'b0);
    #1 checkOutput("hz2_issue", 96'(dutStrobes()),
                   96'(expStrobes(1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 5'd1)));
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h77, 1'b0);
    #1 checkOutput("hz2_cap1", 96'({rf_wen_b, rf_rd_a}), 96'({1'b1, HZ_RD_A}));
    @(negedge clk);
    wb_valid = 1'b0;
    waitRsp(3, lat);
    checkOutput("hz2_latency", 96'(lat), 96'(HZ_LAT));
    checkOutput("hz2_ops", 96'({rsp_op1, rsp_op2}), 96'({32'h5A5A, 32'h77}));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Asynchronous reset in the middle of ISSUE, then a normal request
    drive(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'h99, 1'b0);
    #1 checkOutput("rst_pre_issue", 96'({rf_rd_a, rf_wen_b}), 96'(2'b11));
    #2 rst = 1'b1;
    #1 checkOutput("rst_mid_strobes", 96'(dutStrobes()), 96'(0));
    checkOutput("rst_mid_ops", 96'({rsp_op1, rsp_op2, rf_din_b}), 96'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    wb_valid = 1'b0;
    @(negedge clk);
    #1 checkOutput("rst_after_idle", 96'(dutStrobes()),
                   96'(expStrobes(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0)));
    @(negedge clk);
    drive(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 checkOutput("rst_still_idle", 96'({req_ready, rf_rd_a, rsp_valid}), 96'(3'b100));
    @(negedge clk);
    req_valid = 1'b0;
    #1 checkOutput("rst_req_issue", 96'(dutStrobes()),
                   96'(expStrobes(1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd7)));
    @(negedge clk);
    @(negedge clk);
    #1 checkOutput("rst_req_ops", 96'({rsp_valid, rsp_op1, rsp_op2}), {31'd0, 1'b1, 32'hAB, 32'h77});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 checkOutput("rst_req_done", 96'({req_ready, rsp_valid}), 96'(2'b10));

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
